alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, operand/result width.
REQ-002 SHALL have parameter ADDR_LEN, default 32, pc width.
REQ-003 SHALL have parameter OPENUM_LEN, default 6, opcode-enum width; opcode values are the shared OPENUM_* defines.
REQ-004 SHALL have parameter ROB_LEN, default 4; ROB tags are ROB_LEN+1 bits, and tag 0 means invalid.
REQ-005 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port ena_from_rs, input, 1, issue valid from the reservation station.
REQ-008 SHALL have ports openum_from_rs, V1_from_rs, V2_from_rs, pc_from_rs, imm_from_rs and rob_id_from_rs, all inputs, widths OPENUM_LEN, DATA_LEN, DATA_LEN, ADDR_LEN, DATA_LEN and ROB_LEN+1, carrying the issued operation.
REQ-009 SHALL have port rollback, input, 1, misprediction flush.
REQ-010 SHALL have port cdb_grant, input, 1, CDB arbiter accepts the current result this cycle.
REQ-011 SHALL have port stall_to_rs, output, 1, combinational; when high, the RS must not issue.
REQ-012 SHALL have port valid_to_cdb, output, 1, result register holds a valid result.
REQ-013 SHALL have ports rob_id_to_cdb (ROB_LEN+1), result_to_cdb (DATA_LEN), target_pc_to_cdb (ADDR_LEN) and jump_to_cdb (1), all outputs, all registered.

Function
REQ-014 SHALL have two stages: S1 is the operand latch (s1_valid); S2 is the result register that drives the *_to_cdb outputs, with valid_to_cdb equal to s2_valid.
REQ-015 SHALL accept an issue when ena_from_rs=1, stall_to_rs=0, rollback=0, rob_id_from_rs≠0 and openum_from_rs≠OPENUM_NOP; any other issue is silently dropped.
REQ-016 SHALL set stall_to_rs = s1_valid & s2_valid & ~cdb_grant.
REQ-017 SHALL advance S2 when s2_valid=0 or cdb_grant=1: S2 loads the S1 result and s2_valid becomes s1_valid.
REQ-018 SHALL advance S1 whenever S2 advances or s1_valid=0: S1 loads the accepted issue, or clears s1_valid if nothing is accepted.
REQ-019 SHALL hold every S2 output stable while valid_to_cdb=1 and cdb_grant=0.
REQ-020 SHALL present a result on the outputs exactly 2 cycles after acceptance when unstalled, and sustain one result per cycle.
REQ-021 SHALL compute results in S1→S2 logic, modulo 2^DATA_LEN:
 - ADD/ADDI: V1+(V2 or imm).
 - SUB: V1−V2.
 - AND/OR/XOR (register and immediate forms).
 - SLL/SRL/SRA: shift amount is bits [4:0] of V2 or imm.
 - SLT/SLTU (and immediate forms): result 1 or 0.
 - LUI: result=imm.
 - AUIPC: result=pc+imm.
REQ-022 SHALL resolve JAL as result=pc+4, target=pc+imm, jump=1.
REQ-023 SHALL resolve JALR as result=pc+4, target=(V1+imm)&~1, jump=1.
REQ-024 SHALL resolve BEQ/BNE/BLT/BGE/BLTU/BGEU as result=0, target=pc+imm, jump=condition (signed compare for BLT/BGE, unsigned for BLTU/BGEU).
REQ-025 SHALL drive target=pc+4 and jump=0 for every non-control operation.
REQ-026 SHALL, on rollback=1, clear s1_valid and s2_valid at that edge, drop any same-cycle issue, and ignore cdb_grant; rollback has priority over every other event.
REQ-027 SHALL treat any unlisted opcode as result=0, jump=0, and still deliver it to the CDB.

Reset
REQ-028 SHALL, while rst=0 and independent of clk, set s1_valid=0, s2_valid=0 and clear all S1/S2 data, so all outputs read 0 and stall_to_rs=0.
REQ-029 SHALL, on reset mid-operation, discard in-flight results with no partial CDB output; the first issue is accepted on the first rising edge after rst=1.

Verification
REQ-030 Back-to-back: ADDI V1=5, imm=−7, rob 3, then SUB V1=1, V2=2, rob 4, cdb_grant=1 → cycle+2: result 0xFFFFFFFE, rob 3; cycle+3: 0xFFFFFFFF, rob 4.
REQ-031 Stall: fill both stages with cdb_grant=0 → stall_to_rs=1 and outputs frozen for 5 cycles; raising grant gives both results in order with no loss or duplication.
REQ-032 Branches: BLT V1=0xFFFFFFFF, V2=1 → jump=1; BLTU with same operands → jump=0; target=pc+imm for both; JALR V1=0x1003, imm=0 → target 0x1002, result pc+4.
REQ-033 Rollback with S1 and S2 full plus a same-cycle issue → next cycle valid_to_cdb=0, stall_to_rs=0, and nothing from those ops ever reaches the CDB.
REQ-034 Async reset pulsed between edges with valid results in flight → outputs 0 immediately; issue of rob 1 after release → result after 2 cycles.
REQ-035 Issues with rob_id 0 or OPENUM_NOP → never appear on the CDB.

Source files
------------

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe -- two-stage integer ALU / branch-resolution unit.
//
// Accepts one operation per cycle from the reservation station, latches it in
// S1, computes result / branch target / jump decision on the S1->S2 path and
// holds the outcome in S2, which drives the common data bus (CDB) directly.
//
// Ports
//   clk               clock, all state changes on its rising edge
//   rst               asynchronous active-low reset
//   ena_from_rs       issue valid from the reservation station
//   openum_from_rs    operation enum (OPENUM_* values)
//   V1_from_rs        first source operand
//   V2_from_rs        second source operand
//   pc_from_rs        pc of the issued instruction
//   imm_from_rs       immediate
//   rob_id_from_rs    ROB tag (0 = invalid)
//   rollback          misprediction flush, highest priority
//   cdb_grant         CDB arbiter takes the current result this cycle
//   stall_to_rs       combinational back-pressure to the reservation station
//   valid_to_cdb      S2 holds a valid result
//   rob_id_to_cdb     ROB tag of the result
//   result_to_cdb     result value
//   target_pc_to_cdb  next pc (pc+4 for non-control operations)
//   jump_to_cdb       control transfer taken
// -----------------------------------------------------------------------------

`ifndef OPENUM_NOP
`define OPENUM_NOP   6'd0
`define OPENUM_LUI   6'd1
`define OPENUM_AUIPC 6'd2
`define OPENUM_JAL   6'd3
`define OPENUM_JALR  6'd4
`define OPENUM_BEQ   6'd5
`define OPENUM_BNE   6'd6
`define OPENUM_BLT   6'd7
`define OPENUM_BGE   6'd8
`define OPENUM_BLTU  6'd9
`define OPENUM_BGEU  6'd10
`define OPENUM_ADD   6'd11
`define OPENUM_SUB   6'd12
`define OPENUM_SLL   6'd13
`define OPENUM_SLT   6'd14
`define OPENUM_SLTU  6'd15
`define OPENUM_XOR   6'd16
`define OPENUM_SRL   6'd17
`define OPENUM_SRA   6'd18
`define OPENUM_OR    6'd19
`define OPENUM_AND   6'd20
`define OPENUM_ADDI  6'd21
`define OPENUM_SLTI  6'd22
`define OPENUM_SLTIU 6'd23
`define OPENUM_XORI  6'd24
`define OPENUM_ORI   6'd25
`define OPENUM_ANDI  6'd26
`define OPENUM_SLLI  6'd27
`define OPENUM_SRLI  6'd28
`define OPENUM_SRAI  6'd29
`endif

module alu_pipe #(
    parameter int DATA_LEN   = 32,
    parameter int ADDR_LEN   = 32,
    parameter int OPENUM_LEN = 6,
    parameter int ROB_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ena_from_rs,
    input  logic [OPENUM_LEN-1:0] openum_from_rs,
    input  logic [DATA_LEN-1:0]   V1_from_rs,
    input  logic [DATA_LEN-1:0]   V2_from_rs,
    input  logic [ADDR_LEN-1:0]   pc_from_rs,
    input  logic [DATA_LEN-1:0]   imm_from_rs,
    input  logic [ROB_LEN:0]      rob_id_from_rs,

    input  logic                  rollback,
    input  logic                  cdb_grant,

    output logic                  stall_to_rs,
    output logic                  valid_to_cdb,
    output logic [ROB_LEN:0]      rob_id_to_cdb,
    output logic [DATA_LEN-1:0]   result_to_cdb,
    output logic [ADDR_LEN-1:0]   target_pc_to_cdb,
    output logic                  jump_to_cdb
);

    // Handshakes
    //   Issue side: an operation transfers on a rising edge where ena_from_rs=1
    //   and stall_to_rs=0 (and no rollback). stall_to_rs plays the role of
    //   ~ready; an issue offered while stalled is dropped, not queued, so the
    //   RS is expected to hold off while stall_to_rs=1.
    //   CDB side: a result transfers on a rising edge where valid_to_cdb=1 and
    //   cdb_grant=1. While valid_to_cdb=1 and cdb_grant=0 every *_to_cdb output
    //   is held unchanged.

    // ---------------- S1: operand latch ----------------
    logic                  s1_valid;
    logic [OPENUM_LEN-1:0] s1_op;
    logic [DATA_LEN-1:0]   s1_v1;
    logic [DATA_LEN-1:0]   s1_v2;
    logic [ADDR_LEN-1:0]   s1_pc;
    logic [DATA_LEN-1:0]   s1_imm;
    logic [ROB_LEN:0]      s1_rob;

    // ---------------- S2: result register ----------------
    logic                  s2_valid;
    logic [ROB_LEN:0]      s2_rob;
    logic [DATA_LEN-1:0]   s2_result;
    logic [ADDR_LEN-1:0]   s2_target;
    logic                  s2_jump;

    // ---------------- pipeline control ----------------
    logic s2_adv;
    logic s1_adv;
    logic issue_ok;

    // S2 moves when it is empty or its content is being taken by the CDB.
    assign s2_adv      = ~s2_valid | cdb_grant;
    // S1 moves when S2 moves or S1 is empty; this is exactly ~stall_to_rs.
    assign s1_adv      = s2_adv | ~s1_valid;
    assign stall_to_rs = s1_valid & s2_valid & ~cdb_grant;

    // Tag 0 and NOP carry no work and never occupy the pipe.
    assign issue_ok = ena_from_rs & ~stall_to_rs & ~rollback
                    & (rob_id_from_rs != '0)
                    & (openum_from_rs != `OPENUM_NOP);

    // ---------------- S1 -> S2 compute ----------------
    logic [4:0]          shamt;
    logic [ADDR_LEN-1:0] imm_a;       // immediate sign-extended/truncated to pc width
    logic [DATA_LEN-1:0] pc_d;        // pc resized to data width
    logic [ADDR_LEN-1:0] pc_plus4;
    logic [ADDR_LEN-1:0] pc_plus_imm;
    logic [DATA_LEN-1:0] pc_plus4_d;
    logic [DATA_LEN-1:0] jalr_sum;

    logic [DATA_LEN-1:0] alu_res;
    logic [ADDR_LEN-1:0] alu_tgt;
    logic                alu_jmp;

    // Immediate shift forms take the amount from imm, register forms from V2.
    assign shamt = ((s1_op == `OPENUM_SLLI) || (s1_op == `OPENUM_SRLI) ||
                    (s1_op == `OPENUM_SRAI)) ? s1_imm[4:0] : s1_v2[4:0];

    assign imm_a       = ADDR_LEN'($signed(s1_imm));
    assign pc_d        = DATA_LEN'(s1_pc);
    assign pc_plus4    = s1_pc + ADDR_LEN'(4);
    assign pc_plus_imm = s1_pc + imm_a;
    assign pc_plus4_d  = DATA_LEN'(pc_plus4);
    assign jalr_sum    = s1_v1 + s1_imm;

    always_comb begin
        alu_res = '0;
        alu_tgt = pc_plus4;
        alu_jmp = 1'b0;
        case (s1_op)
            `OPENUM_ADD:   alu_res = s1_v1 + s1_v2;
            `OPENUM_ADDI:  alu_res = s1_v1 + s1_imm;
            `OPENUM_SUB:   alu_res = s1_v1 - s1_v2;
            `OPENUM_AND:   alu_res = s1_v1 & s1_v2;
            `OPENUM_ANDI:  alu_res = s1_v1 & s1_imm;
            `OPENUM_OR:    alu_res = s1_v1 | s1_v2;
            `OPENUM_ORI:   alu_res = s1_v1 | s1_imm;
            `OPENUM_XOR:   alu_res = s1_v1 ^ s1_v2;
            `OPENUM_XORI:  alu_res = s1_v1 ^ s1_imm;
            `OPENUM_SLL,
            `OPENUM_SLLI:  alu_res = s1_v1 << shamt;
            `OPENUM_SRL,
            `OPENUM_SRLI:  alu_res = s1_v1 >> shamt;
            `OPENUM_SRA,
            `OPENUM_SRAI:  alu_res = DATA_LEN'($signed(s1_v1) >>> shamt);
            `OPENUM_SLT:   alu_res = DATA_LEN'($signed(s1_v1) < $signed(s1_v2));
            `OPENUM_SLTI:  alu_res = DATA_LEN'($signed(s1_v1) < $signed(s1_imm));
            `OPENUM_SLTU:  alu_res = DATA_LEN'(s1_v1 < s1_v2);
            `OPENUM_SLTIU: alu_res = DATA_LEN'(s1_v1 < s1_imm);
            `OPENUM_LUI:   alu_res = s1_imm;
            `OPENUM_AUIPC: alu_res = pc_d + s1_imm;
            `OPENUM_JAL: begin
                alu_res = pc_plus4_d;
                alu_tgt = pc_plus_imm;
                alu_jmp = 1'b1;
            end
            `OPENUM_JALR: begin
                alu_res = pc_plus4_d;
                // Low bit is forced clear so the target is always halfword aligned.
                alu_tgt = ADDR_LEN'(jalr_sum) & ~ADDR_LEN'(1);
                alu_jmp = 1'b1;
            end
            `OPENUM_BEQ: begin
                alu_tgt = pc_plus_imm;
                alu_jmp = (s1_v1 == s1_v2);
            end
            `OPENUM_BNE: begin
                alu_tgt = pc_plus_imm;
                alu_jmp = (s1_v1 != s1_v2);
            end
            `OPENUM_BLT: begin
                alu_tgt = pc_plus_imm;
                alu_jmp = ($signed(s1_v1) < $signed(s1_v2));
            end
            `OPENUM_BGE: begin
                alu_tgt = pc_plus_imm;
                alu_jmp = ($signed(s1_v1) >= $signed(s1_v2));
            end
            `OPENUM_BLTU: begin
                alu_tgt = pc_plus_imm;
                alu_jmp = (s1_v1 < s1_v2);
            end
            `OPENUM_BGEU: begin
                alu_tgt = pc_plus_imm;
                alu_jmp = (s1_v1 >= s1_v2);
            end
            // Unknown operations still travel to the CDB with a zero result
            // so the ROB entry retires instead of hanging.
            default: begin
                alu_res = '0;
                alu_tgt = pc_plus4;
                alu_jmp = 1'b0;
            end
        endcase
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_op     <= '0;
            s1_v1     <= '0;
            s1_v2     <= '0;
            s1_pc     <= '0;
            s1_imm    <= '0;
            s1_rob    <= '0;
            s2_valid  <= 1'b0;
            s2_rob    <= '0;
            s2_result <= '0;
            s2_target <= '0;
            s2_jump   <= 1'b0;
        end else if (rollback) begin
            // Flush wins over grant and issue: everything in flight is wrong-path.
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid  <= s1_valid;
                s2_rob    <= s1_rob;
                s2_result <= alu_res;
                s2_target <= alu_tgt;
                s2_jump   <= alu_jmp;
            end
            if (s1_adv) begin
                s1_valid <= issue_ok;
                if (issue_ok) begin
                    s1_op  <= openum_from_rs;
                    s1_v1  <= V1_from_rs;
                    s1_v2  <= V2_from_rs;
                    s1_pc  <= pc_from_rs;
                    s1_imm <= imm_from_rs;
                    s1_rob <= rob_id_from_rs;
                end
            end
        end
    end

    // ---------------- CDB outputs ----------------
    assign valid_to_cdb     = s2_valid;
    assign rob_id_to_cdb    = s2_rob;
    assign result_to_cdb    = s2_result;
    assign target_pc_to_cdb = s2_target;
    assign jump_to_cdb      = s2_jump;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe -- self-checking bench for alu_pipe.
// Inputs change 1 ns after each rising edge; outputs are checked on the
// falling edge. A small occupancy model (m_s1/m_s2) plus an expected-result
// queue predicts stall, valid and the CDB payload every cycle.
// -----------------------------------------------------------------------------

`ifndef OPENUM_NOP
`define OPENUM_NOP   6'd0
`define OPENUM_LUI   6'd1
`define OPENUM_AUIPC 6'd2
`define OPENUM_JAL   6'd3
`define OPENUM_JALR  6'd4
`define OPENUM_BEQ   6'd5
`define OPENUM_BNE   6'd6
`define OPENUM_BLT   6'd7
`define OPENUM_BGE   6'd8
`define OPENUM_BLTU  6'd9
`define OPENUM_BGEU  6'd10
`define OPENUM_ADD   6'd11
`define OPENUM_SUB   6'd12
`define OPENUM_SLL   6'd13
`define OPENUM_SLT   6'd14
`define OPENUM_SLTU  6'd15
`define OPENUM_XOR   6'd16
`define OPENUM_SRL   6'd17
`define OPENUM_SRA   6'd18
`define OPENUM_OR    6'd19
`define OPENUM_AND   6'd20
`define OPENUM_ADDI  6'd21
`define OPENUM_SLTI  6'd22
`define OPENUM_SLTIU 6'd23
`define OPENUM_XORI  6'd24
`define OPENUM_ORI   6'd25
`define OPENUM_ANDI  6'd26
`define OPENUM_SLLI  6'd27
`define OPENUM_SRLI  6'd28
`define OPENUM_SRAI  6'd29
`endif

module tb_alu_pipe;
    localparam int DL = 32;
    localparam int AL = 32;
    localparam int OL = 6;
    localparam int RL = 4;
    localparam int W  = (RL + 1) + DL + AL + 1;   // {rob, result, target, jump}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          ena_from_rs;
    logic [OL-1:0] openum_from_rs;
    logic [DL-1:0] V1_from_rs;
    logic [DL-1:0] V2_from_rs;
    logic [AL-1:0] pc_from_rs;
    logic [DL-1:0] imm_from_rs;
    logic [RL:0]   rob_id_from_rs;
    logic          rollback;
    logic          cdb_grant;
    logic          stall_to_rs;
    logic          valid_to_cdb;
    logic [RL:0]   rob_id_to_cdb;
    logic [DL-1:0] result_to_cdb;
    logic [AL-1:0] target_pc_to_cdb;
    logic          jump_to_cdb;

    alu_pipe #(.DATA_LEN(DL), .ADDR_LEN(AL), .OPENUM_LEN(OL), .ROB_LEN(RL)) dut (
        .clk              (clk),
        .rst              (rst),
        .ena_from_rs      (ena_from_rs),
        .openum_from_rs   (openum_from_rs),
        .V1_from_rs       (V1_from_rs),
        .V2_from_rs       (V2_from_rs),
        .pc_from_rs       (pc_from_rs),
        .imm_from_rs      (imm_from_rs),
        .rob_id_from_rs   (rob_id_from_rs),
        .rollback         (rollback),
        .cdb_grant        (cdb_grant),
        .stall_to_rs      (stall_to_rs),
        .valid_to_cdb     (valid_to_cdb),
        .rob_id_to_cdb    (rob_id_to_cdb),
        .result_to_cdb    (result_to_cdb),
        .target_pc_to_cdb (target_pc_to_cdb),
        .jump_to_cdb      (jump_to_cdb)
    );

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [W-1:0]  exp_q[$];
    logic          m_s1;
    logic          m_s2;
    logic [W-1:0]  pend_exp;

    logic [OL-1:0] op_tab[32] = '{
        `OPENUM_NOP, `OPENUM_LUI, `OPENUM_AUIPC, `OPENUM_JAL, `OPENUM_JALR,
        `OPENUM_BEQ, `OPENUM_BNE, `OPENUM_BLT, `OPENUM_BGE, `OPENUM_BLTU,
        `OPENUM_BGEU, `OPENUM_ADD, `OPENUM_SUB, `OPENUM_SLL, `OPENUM_SLT,
        `OPENUM_SLTU, `OPENUM_XOR, `OPENUM_SRL, `OPENUM_SRA, `OPENUM_OR,
        `OPENUM_AND, `OPENUM_ADDI, `OPENUM_SLTI, `OPENUM_SLTIU, `OPENUM_XORI,
        `OPENUM_ORI, `OPENUM_ANDI, `OPENUM_SLLI, `OPENUM_SRLI, `OPENUM_SRAI,
        6'd40, 6'd63
    };

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference behaviour of one operation, packed as {rob, result, target, jump}.
    function automatic logic [W-1:0] model(input logic [OL-1:0] op, input logic [DL-1:0] v1,
                                           input logic [DL-1:0] v2, input logic [AL-1:0] pc,
                                           input logic [DL-1:0] imm, input logic [RL:0] rob);
        logic [DL-1:0] res;
        logic [AL-1:0] tgt;
        logic          j;
        logic [AL-1:0] br;
        res = '0;
        tgt = pc + 32'd4;
        j   = 1'b0;
        br  = pc + imm;
        case (op)
            `OPENUM_ADD:   res = v1 + v2;
            `OPENUM_ADDI:  res = v1 + imm;
            `OPENUM_SUB:   res = v1 - v2;
            `OPENUM_AND:   res = v1 & v2;
            `OPENUM_ANDI:  res = v1 & imm;
            `OPENUM_OR:    res = v1 | v2;
            `OPENUM_ORI:   res = v1 | imm;
            `OPENUM_XOR:   res = v1 ^ v2;
            `OPENUM_XORI:  res = v1 ^ imm;
            `OPENUM_SLL:   res = v1 << v2[4:0];
            `OPENUM_SLLI:  res = v1 << imm[4:0];
            `OPENUM_SRL:   res = v1 >> v2[4:0];
            `OPENUM_SRLI:  res = v1 >> imm[4:0];
            `OPENUM_SRA:   res = $signed(v1) >>> v2[4:0];
            `OPENUM_SRAI:  res = $signed(v1) >>> imm[4:0];
            `OPENUM_SLT:   res = ($signed(v1) < $signed(v2))  ? 32'd1 : 32'd0;
            `OPENUM_SLTI:  res = ($signed(v1) < $signed(imm)) ? 32'd1 : 32'd0;
            `OPENUM_SLTU:  res = (v1 < v2)  ? 32'd1 : 32'd0;
            `OPENUM_SLTIU: res = (v1 < imm) ? 32'd1 : 32'd0;
            `OPENUM_LUI:   res = imm;
            `OPENUM_AUIPC: res = pc + imm;
            `OPENUM_JAL:   begin res = pc + 32'd4; tgt = br; j = 1'b1; end
            `OPENUM_JALR:  begin res = pc + 32'd4; tgt = (v1 + imm) & 32'hFFFF_FFFE; j = 1'b1; end
            `OPENUM_BEQ:   begin tgt = br; j = (v1 == v2); end
            `OPENUM_BNE:   begin tgt = br; j = (v1 != v2); end
            `OPENUM_BLT:   begin tgt = br; j = ($signed(v1) <  $signed(v2)); end
            `OPENUM_BGE:   begin tgt = br; j = ($signed(v1) >= $signed(v2)); end
            `OPENUM_BLTU:  begin tgt = br; j = (v1 <  v2); end
            `OPENUM_BGEU:  begin tgt = br; j = (v1 >= v2); end
            default: ;
        endcase
        return {rob, res, tgt, j};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [OL-1:0] op, input logic [DL-1:0] v1, input logic [DL-1:0] v2,
                         input logic [AL-1:0] pc, input logic [DL-1:0] imm, input logic [RL:0] rob);
        ena_from_rs    = 1'b1;
        openum_from_rs = op;
        V1_from_rs     = v1;
        V2_from_rs     = v2;
        pc_from_rs     = pc;
        imm_from_rs    = imm;
        rob_id_from_rs = rob;
        pend_exp       = model(op, v1, v2, pc, imm, rob);
    endtask

    task automatic idle();
        ena_from_rs    = 1'b0;
        openum_from_rs = '0;
        V1_from_rs     = '0;
        V2_from_rs     = '0;
        pc_from_rs     = '0;
        imm_from_rs    = '0;
        rob_id_from_rs = '0;
    endtask

    // One clock: check outputs against the model on the falling edge, advance
    // the model for the coming rising edge, return 1 ns after that edge.
    task automatic cycle();
        logic mstall, acc, s2_adv, s1_adv, n1, n2;
        @(negedge clk);
        mstall = m_s1 & m_s2 & ~cdb_grant;
        check("stall_to_rs", W'(stall_to_rs), W'(mstall));
        check("valid_to_cdb", W'(valid_to_cdb), W'(m_s2));
        if (m_s2)
            check("cdb_payload", {rob_id_to_cdb, result_to_cdb, target_pc_to_cdb, jump_to_cdb}, exp_q[0]);
        acc = ena_from_rs & ~mstall & ~rollback & (rob_id_from_rs != '0)
            & (openum_from_rs != `OPENUM_NOP);
        if (rollback) begin
            exp_q.delete();
            m_s1 = 1'b0;
            m_s2 = 1'b0;
        end else begin
            s2_adv = ~m_s2 | cdb_grant;
            s1_adv = s2_adv | ~m_s1;
            if (m_s2 && cdb_grant) void'(exp_q.pop_front());
            n2 = s2_adv ? m_s1 : m_s2;
            n1 = s1_adv ? acc  : m_s1;
            if (acc) exp_q.push_back(pend_exp);
            m_s1 = n1;
            m_s2 = n2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},  W'(valid_to_cdb), '0);
        check({tag, "_stall"},  W'(stall_to_rs), '0);
        check({tag, "_rob"},    W'(rob_id_to_cdb), '0);
        check({tag, "_result"}, W'(result_to_cdb), '0);
        check({tag, "_target"}, W'(target_pc_to_cdb), '0);
        check({tag, "_jump"},   W'(jump_to_cdb), '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b0;
        rollback  = 1'b0;
        cdb_grant = 1'b0;
        m_s1      = 1'b0;
        m_s2      = 1'b0;
        pend_exp  = '0;
        idle();

        // Reset state, with an issue offered during reset that must be ignored.
        drive(`OPENUM_ADD, 32'd1, 32'd1, 32'h0, 32'h0, 5'd9);
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // First issue on the first edge after release, then REQ-030 pair.
        cdb_grant = 1'b1;
        drive(`OPENUM_ADDI, 32'd5, 32'd0, 32'h40, 32'hFFFF_FFF9, 5'd3);
        pend_exp = {5'd3, 32'hFFFF_FFFE, 32'h44, 1'b0};
        cycle();
        drive(`OPENUM_SUB, 32'd1, 32'd2, 32'h44, 32'h0, 5'd4);
        pend_exp = {5'd4, 32'hFFFF_FFFF, 32'h48, 1'b0};
        cycle();
        idle();
        repeat (3) cycle();

        // Stall: fill both stages without grant, keep offering a third op.
        cdb_grant = 1'b0;
        drive(`OPENUM_XOR, 32'hF0F0_0000, 32'h0FF0_1234, 32'h100, 32'h0, 5'd5);
        cycle();
        drive(`OPENUM_SRA, 32'h8000_0010, 32'h0000_0024, 32'h104, 32'h0, 5'd6);
        cycle();
        drive(`OPENUM_LUI, 32'h0, 32'h0, 32'h108, 32'hABCD_E000, 5'd7);
        repeat (6) cycle();
        cdb_grant = 1'b1;
        cycle();
        idle();
        repeat (4) cycle();

        // Branch / jump directed cases with hand-computed expectations.
        drive(`OPENUM_BLT, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 5'd8);
        pend_exp = {5'd8, 32'h0, 32'h120, 1'b1};
        cycle();
        drive(`OPENUM_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 5'd9);
        pend_exp = {5'd9, 32'h0, 32'h120, 1'b0};
        cycle();
        drive(`OPENUM_JALR, 32'h1003, 32'd0, 32'h200, 32'h0, 5'd10);
        pend_exp = {5'd10, 32'h204, 32'h1002, 1'b1};
        cycle();
        drive(`OPENUM_JAL, 32'h0, 32'd0, 32'h300, 32'hFFFF_FFF0, 5'd11);
        pend_exp = {5'd11, 32'h304, 32'h2F0, 1'b1};
        cycle();
        drive(6'd40, 32'h55, 32'h66, 32'h400, 32'h7, 5'd12);
        pend_exp = {5'd12, 32'h0, 32'h404, 1'b0};
        cycle();
        idle();
        repeat (3) cycle();

        // Rollback with both stages full plus a same-cycle issue.
        cdb_grant = 1'b0;
        drive(`OPENUM_ADD, 32'd10, 32'd20, 32'h500, 32'h0, 5'd13);
        cycle();
        drive(`OPENUM_ADD, 32'd30, 32'd40, 32'h504, 32'h0, 5'd14);
        cycle();
        drive(`OPENUM_ADD, 32'd50, 32'd60, 32'h508, 32'h0, 5'd15);
        cdb_grant = 1'b1;
        rollback  = 1'b1;
        cycle();
        rollback  = 1'b0;
        idle();
        repeat (4) cycle();

        // Async reset pulsed between edges with results in flight.
        cdb_grant = 1'b0;
        drive(`OPENUM_OR, 32'h1, 32'h2, 32'h600, 32'h0, 5'd16);
        cycle();
        drive(`OPENUM_AND, 32'hFF, 32'h0F, 32'h604, 32'h0, 5'd17);
        cycle();
        idle();
        cycle();
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        #1;
        rst = 1'b1;
        exp_q.delete();
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        cdb_grant = 1'b1;
        drive(`OPENUM_ADD, 32'd7, 32'd8, 32'h700, 32'h0, 5'd1);
        pend_exp = {5'd1, 32'd15, 32'h704, 1'b0};
        cycle();
        idle();
        repeat (3) cycle();

        // Dropped issues: tag 0 and NOP.
        drive(`OPENUM_ADD, 32'd1, 32'd2, 32'h800, 32'h0, 5'd0);
        cycle();
        drive(`OPENUM_NOP, 32'd1, 32'd2, 32'h804, 32'h0, 5'd18);
        cycle();
        idle();
        repeat (3) cycle();

        // Random traffic with random grant and occasional rollback.
        for (int i = 0; i < 400; i++) begin
            logic [DL-1:0] v1, v2, imm;
            v1  = ($urandom_range(0, 3) == 0) ? DL'($urandom_range(0, 40)) : $urandom();
            v2  = ($urandom_range(0, 3) == 0) ? v1 : $urandom();
            imm = ($urandom_range(0, 1) == 0) ? DL'($signed(12'($urandom()))) : $urandom();
            drive(op_tab[$urandom_range(0, 31)], v1, v2, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                  imm, (RL+1)'($urandom_range(0, 31)));
            if ($urandom_range(0, 4) == 0) ena_from_rs = 1'b0;
            cdb_grant = ($urandom_range(0, 3) != 0);
            rollback  = ($urandom_range(0, 39) == 0);
            cycle();
        end
        rollback  = 1'b0;
        cdb_grant = 1'b1;
        idle();
        repeat (4) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
